// File: rtl/uart8_rx_controller_if.sv
// -----------------------------------------------------------------------------
// uart8_rx_controller_if
// Byte stream leaving the UART receive controller's FIFO.
//   m_data   FIFO head byte (valid while m_valid is high)
//   m_valid  FIFO non-empty
//   m_ready  consumer accepts the head byte; a pop happens on m_valid & m_ready
// Modports:
//   master   the controller (drives m_data/m_valid, samples m_ready)
//   slave    the consumer  (samples m_data/m_valid, drives m_ready)
// -----------------------------------------------------------------------------
interface uart8_rx_controller_if;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart8_rx_controller.sv
// -----------------------------------------------------------------------------
// uart8_rx_controller
// Sequencing and buffering controller for an 8-bit UART receiver running on the
// same 16x-oversample clock. It enables the receiver (with a 2-cycle flush that
// forces the receiver into reset), captures each received byte into a FIFO,
// counts framing errors, flags overruns and marks end-of-message after an idle
// gap.
// Ports:
//   clk        16x oversample clock
//   rst        asynchronous, active-high reset
//   enable     level request to run the receiver
//   clear      1-cycle pulse: flush FIFO, clear overrun, err_count, eom arm
//   rx_en      receiver enable
//   rx_busy    receiver busy
//   rx_done    receiver byte done (multi-cycle level)
//   rx_err     receiver framing error (multi-cycle level)
//   rx_data    received byte, valid while rx_done is high
//   m          byte stream out of the FIFO (master modport)
//   level      FIFO occupancy, 0..2**DEPTH_LOG2
//   overrun    sticky: a byte was dropped because the FIFO was full
//   err_count  saturating count of rx_err rising edges
//   eom        1-cycle pulse: idle gap elapsed after at least one captured byte
//   running    controller is in RUN
// -----------------------------------------------------------------------------
module uart8_rx_controller #(
   parameter int DEPTH_LOG2 = 3,
   parameter int IDLE_BITS  = 4,
   parameter int ERR_W      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         clear,
   output logic                         rx_en,
   input  logic                         rx_busy,
   input  logic                         rx_done,
   input  logic                         rx_err,
   input  logic [7:0]                   rx_data,
   uart8_rx_controller_if.master        m,
   output logic [DEPTH_LOG2:0]          level,
   output logic                         overrun,
   output logic [ERR_W-1:0]             err_count,
   output logic                         eom,
   output logic                         running
);

   localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] PTR_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [11:0]         IDLE_TERM  = 12'(IDLE_BITS * 16 - 1);

   localparam logic [2:0] S_OFF      = 3'd0;
   localparam logic [2:0] S_FLUSH    = 3'd1;
   localparam logic [2:0] S_RUN      = 3'd2;
   localparam logic [2:0] S_STOPPING = 3'd3;

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic                r_flush_cnt;
   logic                r_rx_en;
   logic                r_running;
   logic                r_done_q;
   logic                r_err_q;
   logic                w_cap;
   logic                w_errp;
   logic                w_pop;
   logic                w_full;
   logic                w_push_ok;
   logic                w_enter_off;
   logic [DEPTH_LOG2:0] r_wr_ptr;
   logic [DEPTH_LOG2:0] r_rd_ptr;
   logic [7:0]          r_mem [DEPTH];
   logic [11:0]         r_idle_cnt;
   logic                r_arm;

   // rx_done / rx_err stay high for about a baud interval; act on rising edges only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values, independent of block ordering.
         r_done_q <= 1'b0;
         r_err_q  <= 1'b0;
      end else begin
         r_done_q <= rx_done;
         r_err_q  <= rx_err;
      end
   end

   assign w_cap  = rx_done & ~r_done_q;
   assign w_errp = rx_err & ~r_err_q;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      // NOTE: the default assignment before the case keeps this block latch-free.
      w_state_nxt = r_state;
      case (r_state)
         S_OFF:      if (enable) w_state_nxt = S_FLUSH;
         S_FLUSH:    if (!enable)         w_state_nxt = S_OFF;
                     else if (r_flush_cnt) w_state_nxt = S_RUN;
         S_RUN:      if (!enable) w_state_nxt = rx_busy ? S_STOPPING : S_OFF;
         // A byte completing while stopping ends the stop early; it is still captured.
         S_STOPPING: if (!rx_busy || w_cap) w_state_nxt = S_OFF;
         default:    w_state_nxt = S_OFF;
      endcase
   end

   assign w_enter_off = (w_state_nxt == S_OFF) && (r_state != S_OFF);

   // rx_en/running are registered from the next state so the receiver sees a
   // glitch-free enable that changes on the same edge as the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_OFF;
         r_flush_cnt <= 1'b0;
         r_rx_en     <= 1'b0;
         r_running   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= (r_state == S_FLUSH);
         r_rx_en     <= (w_state_nxt == S_RUN) || (w_state_nxt == S_STOPPING);
         r_running   <= (w_state_nxt == S_RUN);
      end
   end

   assign rx_en   = r_rx_en;
   assign running = r_running;

   // ---------------------------------------------------------------- FIFO
   assign level     = r_wr_ptr - r_rd_ptr;
   assign w_full    = (level == FULL_LEVEL);
   assign m.m_valid = (level != '0);
   assign m.m_data  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
   assign w_pop     = m.m_valid & m.m_ready;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign w_push_ok = w_cap & ~clear & (~w_full | w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: storage is reset so the head byte reads 0 out of reset rather than X.
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push_ok) begin
         r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= rx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         overrun  <= 1'b0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         overrun  <= 1'b0;
      end else begin
         if (w_pop)          r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_push_ok)      r_wr_ptr <= r_wr_ptr + PTR_ONE;
         else if (w_cap)     overrun  <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- errors
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (clear) begin
         err_count <= '0;
      end else if (w_errp && (err_count != '1)) begin
         err_count <= err_count + ERR_W'(1);
      end
   end

   // ---------------------------------------------------------------- end of message
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle_cnt <= '0;
      end else if (w_cap || rx_busy || w_enter_off) begin
         r_idle_cnt <= '0;
      end else if (r_idle_cnt != IDLE_TERM) begin
         r_idle_cnt <= r_idle_cnt + 12'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_arm <= 1'b0;
         eom   <= 1'b0;
      end else begin
         eom <= 1'b0;
         if (clear) begin
            r_arm <= 1'b0;
         end else if (w_cap) begin
            r_arm <= 1'b1;
         end else if (r_arm && (r_idle_cnt == IDLE_TERM)) begin
            r_arm <= 1'b0;
            eom   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart8_rx_controller.sv
// -----------------------------------------------------------------------------
// tb_uart8_rx_controller
// Self-checking bench for uart8_rx_controller (DEPTH_LOG2=3, IDLE_BITS=4,
// ERR_W=8). The bench plays the receiver itself. FIFO contents, overrun and
// error count are predicted by a queue-based model updated once per clock from
// the driven inputs; FSM and end-of-message timing are checked against
// expected cycle counts.
// -----------------------------------------------------------------------------
module tb_uart8_rx_controller;

   localparam int DEPTH   = 8;
   localparam int ERR_MAX = 255;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       clear;
   logic       rx_en;
   logic       rx_busy;
   logic       rx_done;
   logic       rx_err;
   logic [7:0] rx_data;
   logic [3:0] level;
   logic       overrun;
   logic [7:0] err_count;
   logic       eom;
   logic       running;

   uart8_rx_controller_if s_if ();

   uart8_rx_controller #(
      .DEPTH_LOG2 (3),
      .IDLE_BITS  (4),
      .ERR_W      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .clear     (clear),
      .rx_en     (rx_en),
      .rx_busy   (rx_busy),
      .rx_done   (rx_done),
      .rx_err    (rx_err),
      .rx_data   (rx_data),
      .m         (s_if.master),
      .level     (level),
      .overrun   (overrun),
      .err_count (err_count),
      .eom       (eom),
      .running   (running)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0] mdl_q [$];
   bit         mdl_ovr;
   int         mdl_err;
   bit         prev_done;
   bit         prev_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mdl_q.delete();
      mdl_ovr   = 1'b0;
      mdl_err   = 0;
      prev_done = 1'b0;
      prev_err  = 1'b0;
   endtask

   // Apply one clock edge: update the model from the inputs held this cycle,
   // then advance to 1 time unit after the edge.
   task automatic step();
      bit cap;
      bit errp;
      bit pop;
      cap  = rx_done && !prev_done;
      errp = rx_err && !prev_err;
      pop  = (mdl_q.size() != 0) && s_if.m_ready;
      if (clear) begin
         mdl_q.delete();
         mdl_ovr = 1'b0;
         mdl_err = 0;
      end else begin
         if (pop) void'(mdl_q.pop_front());
         if (cap) begin
            if (mdl_q.size() < DEPTH) mdl_q.push_back(rx_data);
            else                      mdl_ovr = 1'b1;
         end
         if (errp && mdl_err < ERR_MAX) mdl_err++;
      end
      prev_done = rx_done;
      prev_err  = rx_err;
      @(posedge clk);
      #1;
   endtask

   task automatic check_fifo(input string tag);
      check({tag, "_valid"}, s_if.m_valid, mdl_q.size() != 0);
      check({tag, "_level"}, level, mdl_q.size());
      if (mdl_q.size() != 0) check({tag, "_data"}, s_if.m_data, mdl_q[0]);
      check({tag, "_ovr"}, overrun, mdl_ovr);
      check({tag, "_errc"}, err_count, mdl_err);
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      rx_data = b;
      rx_done = 1'b1;
      repeat (hold) step();
      rx_done = 1'b0;
      step();
   endtask

   task automatic pop_one(input string tag);
      check(tag, s_if.m_data, mdl_q[0]);
      s_if.m_ready = 1'b1;
      step();
      s_if.m_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   // Wait up to 'budget' edges; report the first edge index at which eom was
   // seen (-1 if never) and how many eom cycles occurred. rx_done is held for
   // the first 15 edges, rx_busy for edges busy_lo..busy_hi.
   task automatic watch_eom(input int budget, input int busy_lo, input int busy_hi,
                            output int first, output int pulses);
      first  = -1;
      pulses = 0;
      for (int k = 1; k <= budget; k++) begin
         rx_done = (k < 16);
         rx_busy = (k >= busy_lo) && (k <= busy_hi);
         step();
         if (eom === 1'b1) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      rx_done = 1'b0;
      rx_busy = 1'b0;
   endtask

   initial begin
      int         first;
      int         pulses;
      logic [7:0] nb;

      rst = 1'b1; enable = 1'b0; clear = 1'b0; rx_busy = 1'b0;
      rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00; s_if.m_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_en",   rx_en, 0);
      check("rst_valid",   s_if.m_valid, 0);
      check("rst_data",    s_if.m_data, 0);
      check("rst_level",   level, 0);
      check("rst_ovr",     overrun, 0);
      check("rst_errc",    err_count, 0);
      check("rst_eom",     eom, 0);
      check("rst_running", running, 0);
      rst = 1'b0;
      step();

      // Enable dropped during FLUSH returns to OFF
      enable = 1'b1;
      step();
      check("abort_flush_en", rx_en, 0);
      enable = 1'b0;
      repeat (4) step();
      check("abort_running", running, 0);
      check("abort_rx_en",   rx_en, 0);

      // T1: two FLUSH cycles with rx_en low, then RUN
      enable = 1'b1;
      step();
      check("t1_flush0", rx_en, 0);
      step();
      check("t1_flush1", rx_en, 0);
      step();
      check("t1_run_en", rx_en, 1);
      check("t1_running", running, 1);

      // T2: 16-cycle done pulse pushes exactly one byte
      rx_data = 8'hA5;
      rx_done = 1'b1;
      step();
      check("t2_valid", s_if.m_valid, 1);
      check("t2_data",  s_if.m_data, 8'hA5);
      check("t2_level", level, 1);
      repeat (15) step();
      rx_done = 1'b0;
      step();
      check("t2_level_after", level, 1);
      pop_one("t2_pop");
      check_fifo("t2_end");

      // T3: nine bytes into an 8-deep FIFO, byte 8 is lost
      for (int i = 0; i < 9; i++) send_byte(8'(i), $urandom_range(1, 4));
      check("t3_level", level, 8);
      check("t3_ovr",   overrun, 1);
      for (int i = 0; i < 8; i++) begin
         check("t3_order", s_if.m_data, i);
         s_if.m_ready = 1'b1;
         step();
         s_if.m_ready = 1'b0;
      end
      check_fifo("t3_end");

      // T4: push into a full FIFO with a simultaneous pop
      pulse_clear();
      check_fifo("t4_clear");
      for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), $urandom_range(1, 3));
      nb = 8'($urandom);
      rx_data = nb;
      rx_done = 1'b1;
      s_if.m_ready = 1'b1;
      step();
      s_if.m_ready = 1'b0;
      repeat (3) step();
      rx_done = 1'b0;
      step();
      check("t4_level", level, 8);
      check("t4_ovr",   overrun, 0);
      repeat (DEPTH - 1) pop_one("t4_pop");
      check("t4_last", s_if.m_data, nb);
      pop_one("t4_pop_last");
      check_fifo("t4_end");

      // T5: error edges counted, saturate, clear wins over a same-cycle edge
      for (int n = 0; n < 3; n++) begin
         rx_err = 1'b1;
         repeat (16) step();
         rx_err = 1'b0;
         repeat ($urandom_range(1, 5)) step();
      end
      check("t5_three", err_count, 3);
      repeat (ERR_MAX - 3) begin
         rx_err = 1'b1; step();
         rx_err = 1'b0; step();
      end
      check("t5_sat", err_count, ERR_MAX);
      rx_err = 1'b1; step();
      rx_err = 1'b0; step();
      check("t5_sat_hold", err_count, ERR_MAX);
      rx_err = 1'b1;
      clear  = 1'b1;
      step();
      clear  = 1'b0;
      check("t5_clear", err_count, 0);
      rx_err = 1'b0;
      step();
      check("t5_clear_hold", err_count, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         if (rx_done) begin
            if ($urandom_range(0, 3) == 0) rx_done = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            rx_done = 1'b1;
            rx_data = 8'($urandom);
         end
         if ($urandom_range(0, 7) == 0) rx_err = ~rx_err;
         s_if.m_ready = ($urandom_range(0, 2) == 0);
         clear        = ($urandom_range(0, 60) == 0);
         step();
         check_fifo("rnd");
      end
      rx_done = 1'b0; rx_err = 1'b0; clear = 1'b0; s_if.m_ready = 1'b0;
      repeat (2) step();
      check_fifo("rnd_end");

      // T6: eom 64 cycles after a capture
      pulse_clear();
      step();
      rx_data = 8'($urandom);
      rx_done = 1'b1;
      step();
      watch_eom(120, 1000, 0, first, pulses);
      check("t6_eom_at",     first, 64);
      check("t6_eom_pulses", pulses, 1);

      // busy resets the idle counter: last busy edge 29, eom 64 edges later
      rx_data = 8'($urandom);
      rx_done = 1'b1;
      step();
      watch_eom(150, 10, 29, first, pulses);
      check("t6_busy_eom_at",     first, 93);
      check("t6_busy_eom_pulses", pulses, 1);

      // Stop while busy: rx_en held until busy falls
      rx_busy = 1'b1;
      enable  = 1'b0;
      step();
      check("t6_stop_en",      rx_en, 1);
      check("t6_stop_running", running, 0);
      repeat (5) step();
      check("t6_stop_hold", rx_en, 1);
      rx_busy = 1'b0;
      step();
      check("t6_stop_off", rx_en, 0);

      // Stop ended by a capture; the byte is kept
      enable = 1'b1;
      repeat (3) step();
      check("t6_rerun", running, 1);
      pulse_clear();
      rx_busy = 1'b1;
      enable  = 1'b0;
      step();
      check("t6_stop2_en", rx_en, 1);
      nb = 8'($urandom);
      rx_data = nb;
      rx_done = 1'b1;
      step();
      check("t6_cap_off", rx_en, 0);
      rx_done = 1'b0;
      rx_busy = 1'b0;
      step();
      check("t6_cap_level", level, 1);
      check("t6_cap_data",  s_if.m_data, nb);

      // RUN with enable low and receiver idle goes straight to OFF
      enable = 1'b1;
      repeat (3) step();
      enable = 1'b0;
      step();
      check("run_to_off", rx_en, 0);

      // Asynchronous reset in the middle of a frame
      enable = 1'b1;
      repeat (3) step();
      rx_data = 8'($urandom);
      rx_done = 1'b1;
      rx_busy = 1'b1;
      step();
      #2;
      rst = 1'b1;
      #1;
      check("arst_rx_en",   rx_en, 0);
      check("arst_level",   level, 0);
      check("arst_valid",   s_if.m_valid, 0);
      check("arst_running", running, 0);
      model_reset();
      rx_done = 1'b0;
      rx_busy = 1'b0;
      enable  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      check_fifo("post_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
